// File: rtl/fetch_queue.sv
// fetch_queue -- instruction prefetch queue between an instruction memory and a consumer.
//
// The fetch PC (fpc) drives the memory request. Each completed handshake pushes the
// fetched {pc, instruction} pair into a DEPTH-entry circular queue. The consumer
// drains the head whenever it is valid and not stalled. A redirect or an interrupt
// flushes the queue and restarts fetch. An interrupt wins over a redirect and records
// the resume address in epc.
//
// Optional feature: define FETCH_BYPASS_EN to forward a completing fetch straight to
// instr/pc4/valid in the same cycle when the queue is empty and the consumer is not
// stalled. The default build (macro undefined) always writes returned data into the
// queue, so valid rises one cycle after the handshake.
//
// Parameters:
//   DEPTH       queue entries, power of 2 in 2..16
//   RESET_PC    fetch address after reset
//   EXC_VECTOR  fetch address taken on an interrupt
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous reset, active low
//   stall        in   consumer cannot accept an instruction this cycle
//   redirect     in   restart fetch at redirect_pc
//   redirect_pc  in   32-bit redirect target (word aligned)
//   irq          in   interrupt request
//   imem_req     out  fetch request valid
//   imem_addr    out  32-bit fetch address
//   imem_ready   in   memory accepts the request and returns data this cycle
//   imem_rdata   in   32-bit instruction word
//   valid        out  instr/pc4 hold a valid instruction
//   instr        out  32-bit head instruction
//   pc4          out  head instruction address + 4
//   epc          out  resume address captured on the last interrupt
module fetch_queue #(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        irq,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc4,
    output logic [31:0] epc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   fpc_q, fpc_d;
    logic [31:0]   epc_q, epc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;

    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];

    logic empty, full, handshake, bypass, push, pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // Gated by reset so no request is visible while the block is held in reset.
    assign imem_req  = reset && !full && !redirect && !irq;
    assign imem_addr = fpc_q;
    assign handshake = imem_req && imem_ready;

`ifdef FETCH_BYPASS_EN
    // Empty queue plus a consumer ready to take the word: hand it over directly.
    assign bypass = empty && handshake && !stall;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed word is consumed on the spot and never occupies a queue slot.
    assign push = handshake && !bypass;
    assign pop  = !empty && !stall && !redirect && !irq;

    assign valid = !empty || bypass;
    assign instr = bypass ? imem_rdata : instr_mem_q[rd_ptr_q];
    assign pc4   = (bypass ? fpc_q : pc_mem_q[rd_ptr_q]) + 32'd4;
    assign epc   = epc_q;

    // Next-state: interrupt beats redirect, both beat normal fetch/drain.
    always_comb begin
        fpc_d    = fpc_q;
        epc_d    = epc_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (irq) begin
            epc_d    = empty ? fpc_q : pc_mem_q[rd_ptr_q];
            fpc_d    = EXC_VECTOR;
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
        end else if (redirect) begin
            fpc_d    = redirect_pc;
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                fpc_d    = fpc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control state: asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpc_q    <= RESET_PC;
            epc_q    <= '0;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            fpc_q    <= fpc_d;
            epc_q    <= epc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Queue storage: data only, contents are qualified by count so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]    <= fpc_q;
            instr_mem_q[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC  = 32'h0000_4180;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        irq;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] epc;

    fetch_queue #(
        .DEPTH      (DEPTH),
        .RESET_PC   (RESET_PC),
        .EXC_VECTOR (EXC_VEC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .irq         (irq),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .valid       (valid),
        .instr       (instr),
        .pc4         (pc4),
        .epc         (epc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    // Reference model: the queue is a plain list of {pc, instruction} pairs.
    ent_t        mq[$];
    ent_t        sbq[$];
    logic [31:0] m_fpc;
    logic [31:0] m_epc;
    int          checks = 0;
    int          errors = 0;
    bit          done   = 0;

    function automatic ent_t mk(logic [31:0] a, logic [31:0] b);
        ent_t e;
        e.pc  = a;
        e.ins = b;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset      = 1'b0;
            stall      = 1'($urandom);
            imem_ready = 1'b1;
            redirect   = 1'b0;
            irq        = 1'b0;
            imem_rdata = $urandom;
            mq.delete();
            m_fpc = RESET_PC;
            m_epc = 32'h0;
            #1;
            chk("rst_req",   32'(imem_req), 32'h0);
            chk("rst_valid", 32'(valid),    32'h0);
            chk("rst_addr",  imem_addr,     RESET_PC);
            chk("rst_epc",   epc,           32'h0);
        end
    endtask

    task automatic cycle(input bit st, input bit rdy, input bit rd,
                         input logic [31:0] rpc, input bit iq);
        bit   m_req, hs, byp, m_valid;
        ent_t head;
        @(negedge clk);
        reset       = 1'b1;
        stall       = st;
        imem_ready  = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        irq         = iq;
        imem_rdata  = $urandom;
        #1;
        m_req = (mq.size() != DEPTH) && !rd && !iq;
        hs    = m_req && rdy;
        byp   = 1'b0;
`ifdef FETCH_BYPASS_EN
        byp   = (mq.size() == 0) && hs && !st;
`endif
        m_valid = (mq.size() != 0) || byp;
        chk("imem_req",  32'(imem_req), 32'(m_req));
        chk("imem_addr", imem_addr,     m_fpc);
        chk("valid",     32'(valid),    32'(m_valid));
        chk("epc",       epc,           m_epc);
        if (m_valid && !st && !rd && !iq) begin
            head = byp ? mk(m_fpc, imem_rdata) : mq[0];
            sbq.push_back(mk(head.pc + 32'd4, head.ins));
        end
        if (iq) begin
            m_epc = (mq.size() != 0) ? mq[0].pc : m_fpc;
            mq.delete();
            m_fpc = EXC_VEC;
        end else if (rd) begin
            mq.delete();
            m_fpc = rpc;
        end else begin
            if (m_valid && !st && !byp) void'(mq.pop_front());
            if (hs && !byp) begin
                mq.push_back(mk(m_fpc, imem_rdata));
                m_fpc = m_fpc + 32'd4;
            end
        end
    endtask

    // Monitor: whenever the DUT hands over an instruction, compare with the oldest expectation.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!done && reset && valid && !stall && !redirect && !irq) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got pc4 %h, no instruction expected", pc4);
                end else begin
                    e = sbq.pop_front();
                    chk("pc4",   pc4,   e.pc);
                    chk("instr", instr, e.ins);
                end
            end
        end
    end

    initial begin
        reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        irq = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0;
        m_fpc = RESET_PC; m_epc = 32'h0;

        // Streaming fetch after reset release.
        do_reset(3);
        for (int i = 0; i < 6; i++) begin
            cycle(0, 1, 0, 32'h0, 0);
            chk("seq_addr", imem_addr, RESET_PC + 32'(4 * i));
`ifndef FETCH_BYPASS_EN
            if (i == 0) chk("seq_valid0", 32'(valid), 32'h0);
            if (i == 1) chk("seq_valid1", 32'(valid), 32'h1);
`endif
        end

        // Stalled consumer: queue fills, then request drops; drain resumes at 0x3010.
        do_reset(1);
        repeat (6) cycle(1, 1, 0, 32'h0, 0);
        chk("full_req", 32'(imem_req), 32'h0);
        cycle(0, 1, 0, 32'h0, 0);
        cycle(0, 1, 0, 32'h0, 0);
        chk("resume_addr", imem_addr, 32'h0000_3010);
        repeat (4) cycle(0, 1, 0, 32'h0, 0);

        // Memory wait states hold the address.
        do_reset(1);
        cycle(0, 1, 0, 32'h0, 0);
        cycle(0, 1, 0, 32'h0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 32'h0, 0);
            chk("wait_addr", imem_addr, 32'h0000_3008);
        end
        cycle(0, 1, 0, 32'h0, 0);

        // Redirect with three queued entries.
        do_reset(1);
        repeat (3) cycle(1, 1, 0, 32'h0, 0);
        cycle(1, 1, 1, 32'h0000_3400, 0);
        cycle(0, 1, 0, 32'h0, 0);
        chk("redir_valid", 32'(valid), 32'h0);
        chk("redir_addr",  imem_addr,  32'h0000_3400);
        cycle(0, 1, 0, 32'h0, 0);

        // Interrupt and redirect together, head at 0x300C.
        do_reset(1);
        repeat (4) cycle(0, 1, 0, 32'h0, 0);
        cycle(0, 1, 1, 32'h0000_3400, 1);
        cycle(0, 0, 0, 32'h0, 0);
        chk("irq_epc",  epc,       32'h0000_300C);
        chk("irq_addr", imem_addr, EXC_VEC);

        // Fetch PC wraps past the top of the address space.
        cycle(0, 1, 1, 32'hFFFF_FFFC, 0);
        cycle(0, 1, 0, 32'h0, 0);
        cycle(0, 1, 0, 32'h0, 0);
        chk("wrap_addr", imem_addr, 32'h0000_0000);

        // Reset in the middle of a waiting handshake.
        cycle(0, 0, 0, 32'h0, 0);
        do_reset(2);
        cycle(0, 1, 0, 32'h0, 0);
        chk("post_rst_addr", imem_addr, RESET_PC);
        chk("post_rst_req",  32'(imem_req), 32'h1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset(1);
            end else begin
                cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0),
                      ($urandom_range(0, 15) == 0), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00} & 32'hFFFF_FFFC,
                      ($urandom_range(0, 31) == 0));
            end
        end

        #5;
        done = 1'b1;
        chk("scoreboard_empty", 32'(sbq.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
